// File: rtl/rf_scan_ctrl_pkg.sv
// Shared beamforming definitions: scan sequencer state encoding and reader constants.
package rf_scan_ctrl_pkg;

    localparam int SMP_IDX_W   = 16;
    localparam int READER_WRAP = 24099;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REWIND   = 3'd1,
        ST_STREAM   = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_LINE_END = 3'd4,
        ST_ABORT    = 3'd5
    } scan_state_t;

endpackage

// File: rtl/rf_scan_ctrl_line_counter.sv
// Clearable up-counter with a flag raised while the count sits at MAX-1.
module rf_line_counter
    import rf_scan_ctrl_pkg::*;
#(
    parameter int W   = SMP_IDX_W,
    parameter int MAX = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr)
            r_count <= '0;
        else if (i_inc)
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/rf_scan_ctrl.sv
// Scan-line sequencer: sweeps the RF sample reader once per line for a whole frame
// and emits a valid/index strobe aligned with the reader's registered outputs.
module rf_scan_ctrl
    import rf_scan_ctrl_pkg::*;
#(
    parameter int N_SAMPLES = 32,
    parameter int N_LINES   = 8,
    parameter int LINE_W    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic                 i_advance,
    output logic                 o_inc_count,
    output logic                 o_rd_reset,
    output logic                 o_smp_valid,
    output logic [SMP_IDX_W-1:0] o_smp_idx,
    output logic [LINE_W-1:0]    o_line_idx,
    output logic                 o_smp_last,
    output logic                 o_line_done,
    output logic                 o_frame_done,
    output logic                 o_busy
);

    localparam logic [SMP_IDX_W-1:0] N_SMP = SMP_IDX_W'(N_SAMPLES);

    scan_state_t          r_state;
    logic                 r_rd_reset;
    logic                 r_smp_valid;
    logic [SMP_IDX_W-1:0] r_smp_idx;
    logic                 r_smp_last;
    logic                 r_line_done;
    logic                 r_frame_done;
    logic                 r_busy;

    logic [SMP_IDX_W-1:0] w_issued;
    logic                 w_issue_tc;
    logic [LINE_W-1:0]    w_line_idx;
    logic                 w_line_tc;
    logic                 w_inc_count;
    logic                 w_issue_clr;
    logic                 w_line_clr;
    logic                 w_line_inc;

    // Abort and reset also block the issue so the reader never advances past a cancel.
    assign w_inc_count = (r_state == ST_STREAM) && i_advance && !i_abort && !i_reset
                         && (w_issued < N_SMP);
    assign w_issue_clr = (r_state == ST_REWIND);
    assign w_line_clr  = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_line_inc  = (r_state == ST_LINE_END) && !w_line_tc && !i_abort;

    rf_line_counter #(.W(SMP_IDX_W), .MAX(N_SAMPLES)) u_issued (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_issue_clr),
        .i_inc   (w_inc_count),
        .o_count (w_issued),
        .o_tc    (w_issue_tc)
    );

    rf_line_counter #(.W(LINE_W), .MAX(N_LINES)) u_line (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (w_line_clr),
        .i_inc   (w_line_inc),
        .o_count (w_line_idx),
        .o_tc    (w_line_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_rd_reset   <= 1'b0;
            r_smp_valid  <= 1'b0;
            r_smp_idx    <= '0;
            r_smp_last   <= 1'b0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // Sample strobe trails the issue by the reader's one-cycle latency.
            r_smp_valid  <= w_inc_count;
            r_smp_idx    <= w_issued;
            r_smp_last   <= w_inc_count && w_issue_tc;
            r_rd_reset   <= 1'b0;
            r_line_done  <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_state != ST_IDLE && i_abort) begin
                r_state    <= ST_ABORT;
                r_rd_reset <= 1'b1;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start && !i_abort) begin
                            r_state    <= ST_REWIND;
                            r_rd_reset <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_REWIND: r_state <= ST_STREAM;
                    ST_STREAM: begin
                        if (w_inc_count && w_issue_tc)
                            r_state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        r_state      <= ST_LINE_END;
                        r_line_done  <= 1'b1;
                        r_frame_done <= w_line_tc;
                    end
                    ST_LINE_END: begin
                        if (w_line_tc) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= ST_REWIND;
                            r_rd_reset <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_inc_count  = w_inc_count;
    assign o_rd_reset   = r_rd_reset;
    assign o_smp_valid  = r_smp_valid;
    assign o_smp_idx    = r_smp_idx;
    assign o_line_idx   = w_line_idx;
    assign o_smp_last   = r_smp_last;
    assign o_line_done  = r_line_done;
    assign o_frame_done = r_frame_done;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_rf_scan_ctrl.sv
// Bench for rf_scan_ctrl: timeline-model vectors for full frames plus hand sequences
// for abort, mid-frame reset and the single-sample/single-line configuration.
module tb_rf_scan_ctrl;

    localparam int NS   = 32;
    localparam int NL   = 4;
    localparam int LW   = 8;
    localparam int VMAX = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort, advance;

    logic          a_inc, a_rd, a_valid, a_last, a_ld, a_fd, a_busy;
    logic [15:0]   a_idx;
    logic [LW-1:0] a_line;
    logic          b_inc, b_rd, b_valid, b_last, b_ld, b_fd, b_busy;
    logic [15:0]   b_idx;
    logic [LW-1:0] b_line;

    rf_scan_ctrl #(.N_SAMPLES(NS), .N_LINES(NL), .LINE_W(LW)) u_a (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort), .i_advance(advance),
        .o_inc_count(a_inc), .o_rd_reset(a_rd), .o_smp_valid(a_valid), .o_smp_idx(a_idx),
        .o_line_idx(a_line), .o_smp_last(a_last), .o_line_done(a_ld), .o_frame_done(a_fd),
        .o_busy(a_busy)
    );

    rf_scan_ctrl #(.N_SAMPLES(1), .N_LINES(1), .LINE_W(LW)) u_b (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_abort(abort), .i_advance(advance),
        .o_inc_count(b_inc), .o_rd_reset(b_rd), .o_smp_valid(b_valid), .o_smp_idx(b_idx),
        .o_line_idx(b_line), .o_smp_last(b_last), .o_line_done(b_ld), .o_frame_done(b_fd),
        .o_busy(b_busy)
    );

    // Sample reader stand-in for the 32-sample instance: 1-cycle latency, golden data.
    function automatic logic [15:0] golden(input int k);
        golden = 16'((k * 73 + 19) ^ (k << 5));
    endfunction

    logic [15:0] rd_cnt, val1;
    always @(posedge clk) begin
        if (reset || a_rd)
            rd_cnt <= 16'd0;
        else if (a_inc) begin
            val1   <= golden(int'(rd_cnt));
            rd_cnt <= rd_cnt + 16'd1;
        end
    end

    typedef struct {
        logic s, a, adv;
        logic inc, rd, valid, last, ld, fd, busy;
        int   idx;
        int   line;
    } vec_t;

    vec_t vecs [0:VMAX-1];
    int   nv;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic s, input logic a, input logic adv, input logic r);
        @(negedge clk);
        start = s; abort = a; advance = adv; reset = r;
        #1;
    endtask

    // Expected per-cycle timeline of one frame started at vector 0:
    // one rewind cycle, issues on every advance until n are out, drain, line end.
    task automatic build(input int n, input int l, input int mode);
        int t, k;
        for (int i = 0; i < VMAX; i++) begin
            vecs[i] = '{default: 0};
            case (mode)
                0:       vecs[i].adv = 1'b1;
                1:       vecs[i].adv = (i % 2 == 0);
                default: vecs[i].adv = ($urandom_range(0, 3) != 0);
            endcase
        end
        vecs[0].s = 1'b1;
        t = 1;
        for (int ln = 0; ln < l; ln++) begin
            vecs[t].rd = 1'b1; vecs[t].busy = 1'b1; vecs[t].line = ln; t++;
            k = 0;
            while (k < n) begin
                vecs[t].busy = 1'b1; vecs[t].line = ln;
                if (vecs[t].adv) begin
                    vecs[t].inc     = 1'b1;
                    vecs[t+1].valid = 1'b1;
                    vecs[t+1].idx   = k;
                    vecs[t+1].last  = (k == n - 1);
                    k++;
                end
                t++;
            end
            vecs[t].busy = 1'b1; vecs[t].line = ln; t++;
            vecs[t].busy = 1'b1; vecs[t].line = ln; vecs[t].ld = 1'b1;
            vecs[t].fd   = (ln == l - 1); t++;
        end
        if (mode == 2)
            for (int i = 2; i < t; i++)
                if ($urandom_range(0, 11) == 0) vecs[i].s = 1'b1;
        vecs[t+1].s = 1'b1;
        vecs[t+1].a = 1'b1;
        nv = t + 4;
    endtask

    task automatic run_vecs(input int sel, input string tag, input int exp_fd_cyc);
        logic inc, rd, valid, last, ld, fd, busy;
        logic [15:0] idx;
        logic [LW-1:0] line;
        int fd_at;
        fd_at = -1;
        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].s, vecs[i].a, vecs[i].adv, 1'b0);
            if (sel == 0) begin
                inc = a_inc; rd = a_rd; valid = a_valid; last = a_last;
                ld = a_ld; fd = a_fd; busy = a_busy; idx = a_idx; line = a_line;
            end else begin
                inc = b_inc; rd = b_rd; valid = b_valid; last = b_last;
                ld = b_ld; fd = b_fd; busy = b_busy; idx = b_idx; line = b_line;
            end
            check($sformatf("%s[%0d].inc_count", tag, i), 32'(inc), 32'(vecs[i].inc));
            check($sformatf("%s[%0d].rd_reset", tag, i), 32'(rd), 32'(vecs[i].rd));
            check($sformatf("%s[%0d].smp_valid", tag, i), 32'(valid), 32'(vecs[i].valid));
            check($sformatf("%s[%0d].line_done", tag, i), 32'(ld), 32'(vecs[i].ld));
            check($sformatf("%s[%0d].frame_done", tag, i), 32'(fd), 32'(vecs[i].fd));
            check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vecs[i].busy));
            if (vecs[i].busy)
                check($sformatf("%s[%0d].line_idx", tag, i), 32'(line), 32'(vecs[i].line));
            if (vecs[i].valid) begin
                check($sformatf("%s[%0d].smp_idx", tag, i), 32'(idx), 32'(vecs[i].idx));
                check($sformatf("%s[%0d].smp_last", tag, i), 32'(last), 32'(vecs[i].last));
                if (sel == 0)
                    check($sformatf("%s[%0d].val1", tag, i), 32'(val1), 32'(golden(vecs[i].idx)));
            end
            if (fd === 1'b1 && fd_at < 0) fd_at = i;
        end
        if (exp_fd_cyc >= 0)
            check($sformatf("%s.start_to_frame_done", tag), 32'(fd_at), 32'(exp_fd_cyc));
    endtask

    initial begin
        int  n;
        logic found;
        reset = 1'b1; start = 1'b0; abort = 1'b0; advance = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        check("rst.inc_count",  32'(a_inc),   0);
        check("rst.rd_reset",   32'(a_rd),    0);
        check("rst.smp_valid",  32'(a_valid), 0);
        check("rst.smp_idx",    32'(a_idx),   0);
        check("rst.line_idx",   32'(a_line),  0);
        check("rst.smp_last",   32'(a_last),  0);
        check("rst.line_done",  32'(a_ld),    0);
        check("rst.frame_done", 32'(a_fd),    0);
        check("rst.busy",       32'(a_busy),  0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        build(NS, NL, 0); run_vecs(0, "basic", NL * (NS + 3));
        build(NS, NL, 1); run_vecs(0, "throttle", -1);
        for (int r = 0; r < 3; r++) begin
            build(NS, NL, 2); run_vecs(0, $sformatf("rand%0d", r), -1);
        end

        // Abort while issuing sample 10 of line 2.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 300) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            if (a_line == 8'd2 && a_valid && a_idx == 16'd9) found = 1'b1;
            n++;
        end
        check("abort.reach_issue10", 32'(found), 1);
        abort = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("abort.rd_reset",  32'(a_rd),    1);
        check("abort.smp_valid", 32'(a_valid), 0);
        check("abort.busy",      32'(a_busy),  1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("abort.post%0d.busy", i),      32'(a_busy),  0);
            check($sformatf("abort.post%0d.rd_reset", i),  32'(a_rd),    0);
            check($sformatf("abort.post%0d.smp_valid", i), 32'(a_valid), 0);
            check($sformatf("abort.post%0d.line_done", i), 32'(a_ld),    0);
            check($sformatf("abort.post%0d.frame_done", i), 32'(a_fd),   0);
        end

        // Reset during streaming of line 1, with start and abort also raised.
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        found = 1'b0;
        n = 0;
        while (!found && n < 200) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            if (a_line == 8'd1 && a_valid) found = 1'b1;
            n++;
        end
        check("mrst.reach_line1", 32'(found), 1);
        reset = 1'b1; start = 1'b1; abort = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("mrst.inc_count",  32'(a_inc),   0);
        check("mrst.rd_reset",   32'(a_rd),    0);
        check("mrst.smp_valid",  32'(a_valid), 0);
        check("mrst.smp_idx",    32'(a_idx),   0);
        check("mrst.line_idx",   32'(a_line),  0);
        check("mrst.smp_last",   32'(a_last),  0);
        check("mrst.line_done",  32'(a_ld),    0);
        check("mrst.frame_done", 32'(a_fd),    0);
        check("mrst.busy",       32'(a_busy),  0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("mrst.restart.rd_reset", 32'(a_rd),   1);
        check("mrst.restart.line_idx", 32'(a_line), 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("mrst.restart.inc_count", 32'(a_inc), 1);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        check("mrst.restart.smp_valid", 32'(a_valid), 1);
        check("mrst.restart.smp_idx",   32'(a_idx),   0);
        check("mrst.restart.val1",      32'(val1),    32'(golden(0)));

        // Single-sample, single-line configuration.
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        build(1, 1, 0); run_vecs(1, "degen", 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
